// File: rtl/fifo_status_arb_ctrl.sv
// Round-robin burst/tail request controller for NCH write-side FIFOs sharing one
// AXI master request port, with a functional timeout that pulses a per-channel chain reset.
module fifo_status_arb_ctrl #(
  parameter int          NCH       = 4,
  parameter int          CW        = 10,
  parameter int          LSIZE     = 9,
  parameter int          THRESHOLD = 200,
  parameter int          BURST_LEN = 100,
  parameter int unsigned TIMEOUT   = 24'hFFF000,
  parameter int          TCW       = 24,
  localparam int         CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               enable,
  input  logic               f_rst_status,
  input  logic [NCH*CW-1:0]  count,
  input  logic [NCH-1:0]     fifo_empty,
  input  logic [NCH-1:0]     tail,
  input  logic [NCH*LSIZE-1:0] tail_len,
  output logic               req,
  output logic               req_tail,
  output logic [CHW-1:0]     req_ch,
  output logic [LSIZE-1:0]   req_len,
  input  logic               resp,
  input  logic               done,
  output logic               burst_done,
  output logic               tail_done,
  output logic [CHW-1:0]     done_ch,
  output logic [NCH-1:0]     rst_chain,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQ         = 3'd1,
    WAIT_DONE   = 3'd2,
    FSH         = 3'd3,
    TIME_ERR    = 3'd4,
    RESET_CHAIN = 3'd5
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  function automatic logic [TCW-1:0] sat_inc(input logic [TCW-1:0] v);
    return (&v) ? v : v + TCW'(1);
  endfunction

  state_t           state_q, state_d;
  logic [NCH-1:0]   bp_q, bp_d;
  logic [NCH-1:0]   ta_q, ta_set, ta_clr;
  logic [NCH-1:0]   tail_d;
  logic [NCH-1:0]   el;
  logic [CHW-1:0]   rr_q;
  logic [TCW-1:0]   tcnt_q;
  logic             tail_q;

  logic             arb_hit;
  logic [CHW-1:0]   arb_ch;
  logic             arb_tail;
  logic [CW-1:0]    arb_cnt;
  logic [LSIZE-1:0] arb_tlen;
  logic             tmo;
  logic             grant_fire, grant_drop, fsh_enter, to_enter;

  // Stage 0: combinational status decode and round-robin search
  always_comb begin
    bp_d = '0;
    for (int i = 0; i < NCH; i++) begin
      bp_d[i] = int'(count[i*CW +: CW]) >= THRESHOLD;
    end
  end

  assign el     = ~fifo_empty & (ta_q | bp_q);
  assign ta_set = tail & ~tail_d;

  always_comb begin
    int idx;
    idx     = 0;
    arb_hit = 1'b0;
    arb_ch  = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_q) + k) % NCH;
      if (!arb_hit && el[idx]) begin
        arb_hit = 1'b1;
        arb_ch  = CHW'(idx);
      end
    end
  end

  assign arb_tail = ta_q[arb_ch];
  assign arb_cnt  = count[int'(arb_ch)*CW +: CW];
  assign arb_tlen = tail_len[int'(arb_ch)*LSIZE +: LSIZE];

  // tcnt compared with >= so a resp at the expiry cycle still times out in WAIT_DONE
  assign tmo = TO_EN && (tcnt_q >= TO_LAST);

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    grant_drop = 1'b0;
    fsh_enter  = 1'b0;
    to_enter   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && arb_hit) begin
          if (arb_tail && (arb_cnt == '0)) begin
            grant_drop = 1'b1;
          end else begin
            grant_fire = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (resp && done) begin
          fsh_enter = 1'b1;
          state_d   = FSH;
        end else if (resp) begin
          state_d = WAIT_DONE;
        end else if (tmo) begin
          to_enter = 1'b1;
          state_d  = TIME_ERR;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          fsh_enter = 1'b1;
          state_d   = FSH;
        end else if (tmo) begin
          to_enter = 1'b1;
          state_d  = TIME_ERR;
        end
      end
      FSH:         state_d = IDLE;
      TIME_ERR:    state_d = RESET_CHAIN;
      RESET_CHAIN: if (fifo_empty[req_ch]) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    ta_clr = '0;
    if (grant_drop) ta_clr[arb_ch] = 1'b1;
    if ((fsh_enter && tail_q) || to_enter) ta_clr[req_ch] = 1'b1;
  end

  // Stage 1: registered FSM, flags and latched grant
  always_ff @(posedge clock or posedge rst) begin
    if (rst)               state_q <= IDLE;
    else if (f_rst_status) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  // Plain delay for edge detection; a soft clear must not fake a rising edge
  always_ff @(posedge clock or posedge rst) begin
    if (rst) tail_d <= '0;
    else     tail_d <= tail;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bp_q        <= '0;
      ta_q        <= '0;
      rr_q        <= '0;
      tcnt_q      <= '0;
      tail_q      <= 1'b0;
      req_ch      <= '0;
      req_len     <= '0;
      done_ch     <= '0;
      burst_done  <= 1'b0;
      tail_done   <= 1'b0;
      rst_chain   <= '0;
      timeout_err <= 1'b0;
    end else if (f_rst_status) begin
      bp_q        <= '0;
      ta_q        <= '0;
      rr_q        <= '0;
      tcnt_q      <= '0;
      tail_q      <= 1'b0;
      req_ch      <= '0;
      req_len     <= '0;
      done_ch     <= '0;
      burst_done  <= 1'b0;
      tail_done   <= 1'b0;
      rst_chain   <= '0;
      timeout_err <= 1'b0;
    end else begin
      bp_q       <= bp_d;
      ta_q       <= (ta_q & ~ta_clr) | ta_set;
      tcnt_q     <= (state_q == REQ || state_q == WAIT_DONE) ? sat_inc(tcnt_q) : '0;
      burst_done <= fsh_enter & ~tail_q;
      tail_done  <= fsh_enter & tail_q;
      rst_chain  <= to_enter ? (NCH'(1) << req_ch) : '0;
      if (grant_fire) begin
        rr_q    <= arb_ch;
        req_ch  <= arb_ch;
        tail_q  <= arb_tail;
        req_len <= arb_tail ? arb_tlen : LSIZE'(BURST_LEN);
      end
      if (fsh_enter || to_enter) done_ch <= req_ch;
      if (to_enter) timeout_err <= 1'b1;
    end
  end

  assign req      = (state_q == REQ) & ~tail_q;
  assign req_tail = (state_q == REQ) &  tail_q;

endmodule

// File: tb/tb_fifo_status_arb_ctrl.sv
// Bench for fifo_status_arb_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_fifo_status_arb_ctrl;
  localparam int          NCH       = 4;
  localparam int          CW        = 10;
  localparam int          LSIZE     = 9;
  localparam int          THRESHOLD = 200;
  localparam int          BURST_LEN = 100;
  localparam int unsigned TIMEOUT   = 16;
  localparam int          TCW       = 24;
  localparam int          CHW       = 2;

  logic                 clock = 1'b0;
  logic                 rst, enable, f_rst_status;
  logic [NCH*CW-1:0]    count;
  logic [NCH-1:0]       fifo_empty, tail;
  logic [NCH*LSIZE-1:0] tail_len;
  logic                 req, req_tail, resp, done;
  logic [CHW-1:0]       req_ch, done_ch;
  logic [LSIZE-1:0]     req_len;
  logic                 burst_done, tail_done, timeout_err;
  logic [NCH-1:0]       rst_chain;

  int checks = 0;
  int errors = 0;

  fifo_status_arb_ctrl #(
    .NCH(NCH), .CW(CW), .LSIZE(LSIZE), .THRESHOLD(THRESHOLD),
    .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT), .TCW(TCW)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .f_rst_status(f_rst_status),
    .count(count), .fifo_empty(fifo_empty), .tail(tail), .tail_len(tail_len),
    .req(req), .req_tail(req_tail), .req_ch(req_ch), .req_len(req_len),
    .resp(resp), .done(done), .burst_done(burst_done), .tail_done(tail_done),
    .done_ch(done_ch), .rst_chain(rst_chain), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(count[ch*CW +: CW]);
  endfunction

  function automatic int tlen_of(input int ch);
    return int'(tail_len[ch*LSIZE +: LSIZE]);
  endfunction

  task automatic set_cnt(input int ch, input int v);
    count[ch*CW +: CW] = CW'(v);
  endtask

  // ---------------- transaction-level reference model ----------------
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_FSH = 3, P_TERR = 4, P_RCH = 5;
  int  m_phase = P_IDLE;
  int  m_rr = 0, m_age = 0;
  bit  m_bp[NCH], m_ta[NCH], m_prev[NCH];
  int  e_ch = 0, e_len = 0, e_dch = 0;
  bit  e_tail = 0, e_bd = 0, e_td = 0, e_terr = 0;
  logic [NCH-1:0] e_rc = '0;

  task automatic model_clear(input bit keep_prev);
    m_phase = P_IDLE; m_rr = 0; m_age = 0;
    e_ch = 0; e_len = 0; e_dch = 0; e_tail = 0;
    e_bd = 0; e_td = 0; e_terr = 0; e_rc = '0;
    for (int i = 0; i < NCH; i++) begin
      m_bp[i] = 0; m_ta[i] = 0;
      m_prev[i] = keep_prev ? tail[i] : 1'b0;
    end
  endtask

  task automatic finish_xfer();
    m_phase = P_FSH;
    e_dch = e_ch;
    if (e_tail) e_td = 1; else e_bd = 1;
  endtask

  task automatic model_step();
    bit clr[NCH];
    bit found;
    int g, i;
    e_bd = 0; e_td = 0; e_rc = '0;
    if (f_rst_status) begin
      model_clear(1);
      return;
    end
    for (int c = 0; c < NCH; c++) clr[c] = 0;
    found = 0; g = 0;
    case (m_phase)
      P_IDLE: if (enable) begin
        for (int k = 1; k <= NCH; k++) begin
          i = (m_rr + k) % NCH;
          if (!found && !fifo_empty[i] && (m_ta[i] || m_bp[i])) begin
            found = 1; g = i;
          end
        end
        if (found) begin
          if (m_ta[g] && cnt_of(g) == 0) clr[g] = 1;
          else begin
            m_rr = g; e_ch = g; e_tail = m_ta[g];
            e_len = m_ta[g] ? tlen_of(g) : BURST_LEN;
            m_phase = P_REQ; m_age = 1;
          end
        end
      end
      P_REQ, P_WAIT: begin
        if ((m_phase == P_REQ && resp && done) || (m_phase == P_WAIT && done)) begin
          if (e_tail) clr[e_ch] = 1;
          finish_xfer();
        end else if (m_phase == P_REQ && resp) begin
          m_phase = P_WAIT; m_age++;
        end else if (TIMEOUT != 0 && m_age >= int'(TIMEOUT)) begin
          m_phase = P_TERR; e_rc[e_ch] = 1'b1; e_terr = 1; e_dch = e_ch; clr[e_ch] = 1;
        end else m_age++;
      end
      P_FSH:  m_phase = P_IDLE;
      P_TERR: m_phase = P_RCH;
      P_RCH:  if (fifo_empty[e_ch]) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (tail[c] && !m_prev[c]) m_ta[c] = 1;
      else if (clr[c]) m_ta[c] = 0;
      m_bp[c] = cnt_of(c) >= THRESHOLD;
      m_prev[c] = tail[c];
    end
  endtask

  always @(posedge clock or posedge rst) begin
    if (rst) model_clear(0);
    else     model_step();
  end

  always @(negedge clock) begin
    chk("req",         req,         (m_phase == P_REQ && !e_tail) ? 1 : 0);
    chk("req_tail",    req_tail,    (m_phase == P_REQ &&  e_tail) ? 1 : 0);
    chk("req_ch",      req_ch,      e_ch);
    chk("req_len",     req_len,     e_len);
    chk("burst_done",  burst_done,  e_bd);
    chk("tail_done",   tail_done,   e_td);
    chk("done_ch",     done_ch,     e_dch);
    chk("rst_chain",   rst_chain,   e_rc);
    chk("timeout_err", timeout_err, e_terr);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    while (!(req || req_tail) && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_grant_seen"}, (req || req_tail) ? 1 : 0, 1);
  endtask

  int grants[$];
  int exp_rr[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    rst = 1; enable = 1; f_rst_status = 0; count = '0; fifo_empty = '1;
    tail = '0; tail_len = '0; resp = 0; done = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req", req, 0); chk("rst_req_tail", req_tail, 0);
    chk("rst_terr", timeout_err, 0); chk("rst_chain0", rst_chain, 0);
    chk("rst_len", req_len, 0);
    rst = 0;

    // round robin, immediate resp/done
    for (int c = 0; c < NCH; c++) set_cnt(c, 300);
    fifo_empty = '0; resp = 1; done = 1;
    for (int n = 0; n < 60 && grants.size() < 8; n++) begin
      tick();
      if (req) grants.push_back(int'(req_ch));
    end
    chk("rr_count", grants.size(), 8);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk("rr_order", grants[k], exp_rr[k]);
    count = '0;
    repeat (6) tick();
    resp = 0; done = 0;
    repeat (2) tick();

    // burst on ch0: latency, resp later, done later
    set_cnt(0, 200);
    tick(); chk("t1_not_yet", req, 0);
    tick(); chk("t1_req", req, 1); chk("t1_ch", req_ch, 0); chk("t1_len", req_len, 100);
    set_cnt(0, 0);
    repeat (2) tick();
    resp = 1; tick(); resp = 0;
    chk("t1_wait_req_low", req, 0);
    repeat (4) tick();
    done = 1; tick(); done = 0;
    chk("t1_bdone", burst_done, 1); chk("t1_tdone", tail_done, 0); chk("t1_dch", done_ch, 0);
    tick(); chk("t1_bdone_pulse", burst_done, 0);

    // tail on ch2, resp and done together
    set_cnt(2, 37); tail_len[2*LSIZE +: LSIZE] = 9'd37; tail[2] = 1;
    tick(); chk("t3_not_yet", req_tail, 0);
    tick(); chk("t3_req_tail", req_tail, 1); chk("t3_req", req, 0);
    chk("t3_ch", req_ch, 2); chk("t3_len", req_len, 37);
    resp = 1; done = 1; tick(); resp = 0; done = 0;
    chk("t3_tdone", tail_done, 1); chk("t3_bdone", burst_done, 0); chk("t3_dch", done_ch, 2);
    tick(); chk("t3_tdone_pulse", tail_done, 0);
    repeat (4) tick();
    chk("t3_ta_cleared", req_tail, 0);
    tail[2] = 0; set_cnt(2, 0);
    tick(); tail[2] = 1;
    for (int n = 0; n < 6; n++) begin
      tick(); chk("t3_zero_cnt_no_req", req_tail | req, 0);
    end
    tail[2] = 0;
    tick();

    // timeout on ch1, stays in RESET_CHAIN until fifo_empty[1]
    set_cnt(1, 300);
    wait_grant("t4");
    set_cnt(1, 0);
    repeat (15) tick();
    chk("t4_still_req", req, 1);
    tick();
    chk("t4_req_gone", req, 0); chk("t4_rst_chain", rst_chain, 4'b0010);
    chk("t4_terr", timeout_err, 1); chk("t4_dch", done_ch, 1);
    tick(); chk("t4_pulse_end", rst_chain, 0);
    set_cnt(3, 300);
    for (int n = 0; n < 4; n++) begin
      tick(); chk("t4_held", req, 0);
    end
    fifo_empty[1] = 1;
    wait_grant("t4b");
    chk("t4b_ch", req_ch, 3);

    // done arriving on the expiry cycle wins over timeout
    set_cnt(3, 0);
    resp = 1; tick(); resp = 0;
    repeat (14) tick();
    done = 1; tick(); done = 0;
    chk("t5_bdone", burst_done, 1); chk("t5_no_chain", rst_chain, 0); chk("t5_dch", done_ch, 3);
    fifo_empty[1] = 0;
    tick();

    // soft clear in WAIT_DONE with an armed tail on ch2
    set_cnt(0, 300);
    wait_grant("t6");
    resp = 1; tick(); resp = 0;
    set_cnt(2, 37); tail[2] = 1;
    tick();
    f_rst_status = 1; done = 1; tick(); f_rst_status = 0; done = 0;
    set_cnt(0, 0);
    chk("t6_req", req, 0); chk("t6_no_done", burst_done, 0); chk("t6_terr_clr", timeout_err, 0);
    for (int n = 0; n < 5; n++) begin
      tick(); chk("t6_idle", req | req_tail, 0);
    end
    tail[2] = 0;

    // async reset in WAIT_DONE
    set_cnt(0, 300);
    wait_grant("t6b");
    resp = 1; tick(); resp = 0;
    #2 rst = 1;
    #1 chk("t6b_req", req, 0); chk("t6b_len", req_len, 0);
    set_cnt(0, 0);
    tick(); rst = 0;
    chk("t6b_no_done", burst_done, 0);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 4))
            0: set_cnt(c, 0);
            1: set_cnt(c, 37);
            2: set_cnt(c, 199);
            3: set_cnt(c, 200);
            default: set_cnt(c, int'($urandom_range(0, 1023)));
          endcase
        end
        fifo_empty[c] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 5) == 0) begin
          tail[c] = ~tail[c];
          tail_len[c*LSIZE +: LSIZE] = LSIZE'($urandom_range(0, 511));
        end
      end
      resp = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 9) != 0);
      f_rst_status = ($urandom_range(0, 199) == 0);
    end
    f_rst_status = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
